fifo_asynchronous: RTL and testbench

FIFO_ASYNCHRONOUS -- requirements
Module: fifo_asynchronous

---
 rtl/fifo_asynchronous_if.sv | 52 +++++
 rtl/fifo_asynchronous.sv | 107 ++++++++++
 tb/tb_fifo_asynchronous.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fifo_asynchronous_if.sv
// ---------------------------------------------------------------------------
// fifo_asynchronous_if
//
// Purpose:
//   Bundles the write/read handshake and data signals of fifo_asynchronous so
//   the FIFO and its user connect through a single port. Clock and reset are
//   kept outside the interface as plain ports.
//
// Signals:
//   i_wr_en    write request                   (user -> FIFO)
//   i_data_wr  write data, SIZE_DATA bits      (user -> FIFO)
//   o_full     FIFO holds SIZE_DEPTH words     (FIFO -> user)
//   i_rd_en    read request                    (user -> FIFO)
//   o_data_rd  registered read data            (FIFO -> user)
//   o_empty    FIFO holds zero words           (FIFO -> user)
//
// Modports:
//   master  the user side: drives the requests and write data
//   slave   the FIFO side: drives the flags and read data
//
// SIZE_DATA must match the SIZE_DATA of the fifo_asynchronous instance.
// ---------------------------------------------------------------------------
interface fifo_asynchronous_if #(
  parameter int SIZE_DATA = 8
);

  logic                 i_wr_en;
  logic [SIZE_DATA-1:0] i_data_wr;
  logic                 o_full;
  logic                 i_rd_en;
  logic [SIZE_DATA-1:0] o_data_rd;
  logic                 o_empty;

  modport master (
    output i_wr_en,
    output i_data_wr,
    output i_rd_en,
    input  o_full,
    input  o_data_rd,
    input  o_empty
  );

  modport slave (
    input  i_wr_en,
    input  i_data_wr,
    input  i_rd_en,
    output o_full,
    output o_data_rd,
    output o_empty
  );

endinterface : fifo_asynchronous_if

// File: rtl/fifo_asynchronous.sv
// ---------------------------------------------------------------------------
// fifo_asynchronous
//
// Purpose:
//   First-in first-out buffer of SIZE_DEPTH words of SIZE_DATA bits. Despite
//   the historical name, the block is fully synchronous: every register is
//   clocked by i_clk_wr. The i_clk_rd pin is kept for pin compatibility and
//   must be tied to the same clock net; nothing is clocked by it.
//
// Parameters:
//   SIZE_DATA   data word width in bits (default 8)
//   SIZE_DEPTH  storage depth in words, power of two, >= 2 (default 16)
//
// Ports:
//   i_clk_wr  sole clock, rising-edge active
//   i_clk_rd  read clock pin, same net as i_clk_wr, unused internally
//   i_rst_n   synchronous active-low reset, sampled on rising i_clk_wr
//   bus       fifo_asynchronous_if.slave:
//               i_wr_en / i_data_wr  write request and data
//               i_rd_en              read request
//               o_data_rd            registered read data (one-edge latency)
//               o_full / o_empty     occupancy flags from registered pointers
//
// Behaviour summary:
//   - A write is accepted when i_wr_en=1 and the FIFO is not full; a read is
//     accepted when i_rd_en=1 and the FIFO is not empty. Both can be accepted
//     on the same edge. Requests that are not accepted are silently dropped.
//   - o_data_rd loads the oldest word on the edge that accepts a read and
//     otherwise holds.
//   - Reset clears both pointers and o_data_rd; memory contents are kept.
// ---------------------------------------------------------------------------
module fifo_asynchronous #(
  parameter int SIZE_DATA  = 8,
  parameter int SIZE_DEPTH = 16
) (
  input  logic                    i_clk_wr,
  input  logic                    i_clk_rd,
  input  logic                    i_rst_n,
  fifo_asynchronous_if.slave      bus
);

  // Address width and pointer width (one extra wrap bit so that full and
  // empty can be told apart when the address bits are equal).
  localparam int ADDR_W = (SIZE_DEPTH > 1) ? $clog2(SIZE_DEPTH) : 1;
  localparam int PTR_W  = ADDR_W + 1;

  // i_clk_rd is intentionally unused: the read side shares i_clk_wr.
  logic unused_clk_rd;
  assign unused_clk_rd = i_clk_rd;

  logic [SIZE_DATA-1:0] mem [SIZE_DEPTH];

  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [SIZE_DATA-1:0] rd_data_p1;

  logic                 full;
  logic                 empty;
  logic                 wr_accept;
  logic                 rd_accept;
  logic [ADDR_W-1:0]    wr_addr;
  logic [ADDR_W-1:0]    rd_addr;

  assign wr_addr = wr_ptr[ADDR_W-1:0];
  assign rd_addr = rd_ptr[ADDR_W-1:0];

  // Flags come straight from the registered pointers, so they change one
  // edge after the access that changes occupancy.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) && (wr_addr == rd_addr);

  // A write while full and a read while empty are dropped. When full, a
  // simultaneous read still proceeds; when empty, a simultaneous write still
  // proceeds, and that word only becomes readable on a later edge.
  assign wr_accept = bus.i_wr_en && !full;
  assign rd_accept = bus.i_rd_en && !empty;

  // ---- stage p0 -> p1: storage write, pointer update, read register ----

  // Storage has no reset; reset only blocks a write on the reset edge.
  always_ff @(posedge i_clk_wr) begin
    if (i_rst_n && wr_accept) begin
      mem[wr_addr] <= bus.i_data_wr;
    end
  end

  always_ff @(posedge i_clk_wr) begin
    if (!i_rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_data_p1 <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_accept) begin
        rd_ptr     <= rd_ptr + PTR_W'(1);
        rd_data_p1 <= mem[rd_addr];
      end
    end
  end

  assign bus.o_full    = full;
  assign bus.o_empty   = empty;
  assign bus.o_data_rd = rd_data_p1;

endmodule : fifo_asynchronous

// File: tb/tb_fifo_asynchronous.sv
// ---------------------------------------------------------------------------
// tb_fifo_asynchronous
//
// Self-checking bench for fifo_asynchronous (SIZE_DATA=8, SIZE_DEPTH=16).
// A queue-based reference model tracks every applied cycle; a directed
// vector table carries hand-derived expected values, followed by corner
// sequences and randomized traffic with occasional resets.
// ---------------------------------------------------------------------------
module tb_fifo_asynchronous;

  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_asynchronous_if #(.SIZE_DATA(DW)) bus ();

  fifo_asynchronous #(
    .SIZE_DATA (DW),
    .SIZE_DEPTH(DEPTH)
  ) dut (
    .i_clk_wr(clk),
    .i_clk_rd(clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: queue of stored words plus the last read value.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout;

  typedef struct {
    logic          rst_n;
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;
    logic          e_empty;
    logic          e_full;
    logic [DW-1:0] e_dout;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic w, input logic rd, input logic [DW-1:0] d,
                     input logic ee, input logic ef, input logic [DW-1:0] ed);
    vec_t v;
    v.rst_n = r; v.wr = w; v.rd = rd; v.din = d;
    v.e_empty = ee; v.e_full = ef; v.e_dout = ed;
    tbl.push_back(v);
  endtask

  // Apply one cycle of inputs, advance one edge, update the model and
  // compare the DUT against it.
  task automatic step(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
    bit m_full, m_empty;
    rst_n         = r;
    bus.i_wr_en   = w;
    bus.i_rd_en   = rd;
    bus.i_data_wr = d;
    @(posedge clk);
    m_empty = (mq.size() == 0);
    m_full  = (mq.size() == DEPTH);
    if (!r) begin
      mq.delete();
      m_dout = '0;
    end else begin
      if (rd && !m_empty) m_dout = mq.pop_front();
      if (w && !m_full)   mq.push_back(d);
    end
    #1;
    chk("model_empty", 32'(bus.o_empty),   32'(mq.size() == 0));
    chk("model_full",  32'(bus.o_full),    32'(mq.size() == DEPTH));
    chk("model_dout",  32'(bus.o_data_rd), 32'(m_dout));
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.i_wr_en   = 1'b0;
    bus.i_rd_en   = 1'b0;
    bus.i_data_wr = '0;
    m_dout        = '0;

    // ---- directed table with hand-derived expectations ----
    add(0, 0, 0, 8'h00, 1, 0, 8'h00);
    add(0, 1, 1, 8'h77, 1, 0, 8'h00);
    add(1, 0, 0, 8'h00, 1, 0, 8'h00);
    add(1, 0, 0, 8'h00, 1, 0, 8'h00);
    for (int i = 1; i <= 16; i++)
      add(1, 1, 0, 8'(i), 1'b0, (i == 16), 8'h00);
    for (int i = 0; i < 16; i++)
      add(1, 1, 0, 8'hFF, 1'b0, 1'b1, 8'h00);
    for (int i = 1; i <= 16; i++)
      add(1, 0, 1, 8'h00, (i == 16), 1'b0, 8'(i));
    for (int i = 0; i < 5; i++)
      add(1, 0, 1, 8'h00, 1'b1, 1'b0, 8'h10);
    add(1, 1, 0, 8'hA1, 0, 0, 8'h10);
    for (int k = 0; k < 40; k++)
      add(1, 1, 1, 8'(8'hA2 + k), 1'b0, 1'b0, 8'(8'hA1 + k));
    for (int i = 0; i < 5; i++)
      add(1, 1, 0, 8'(8'h31 + i), 1'b0, 1'b0, 8'hC8);
    add(0, 1, 0, 8'h99, 1, 0, 8'h00);
    add(1, 0, 1, 8'h00, 1, 0, 8'h00);

    foreach (tbl[i]) begin
      step(tbl[i].rst_n, tbl[i].wr, tbl[i].rd, tbl[i].din);
      chk($sformatf("vec%0d_empty", i), 32'(bus.o_empty),   32'(tbl[i].e_empty));
      chk($sformatf("vec%0d_full", i),  32'(bus.o_full),    32'(tbl[i].e_full));
      chk($sformatf("vec%0d_dout", i),  32'(bus.o_data_rd), 32'(tbl[i].e_dout));
    end

    // ---- corner: simultaneous write+read while empty ----
    step(0, 0, 0, 8'h00);
    step(1, 1, 1, 8'h55);
    chk("empty_wr_rd_empty", 32'(bus.o_empty),   32'd0);
    chk("empty_wr_rd_dout",  32'(bus.o_data_rd), 32'h00);
    step(1, 0, 1, 8'h00);
    chk("empty_wr_rd_read",  32'(bus.o_data_rd), 32'h55);
    chk("empty_wr_rd_drain", 32'(bus.o_empty),   32'd1);

    // ---- corner: simultaneous write+read while full ----
    for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 8'(8'h60 + i));
    chk("full_reached", 32'(bus.o_full), 32'd1);
    step(1, 1, 1, 8'hEE);
    chk("full_wr_rd_dout", 32'(bus.o_data_rd), 32'h60);
    chk("full_wr_rd_full", 32'(bus.o_full),    32'd0);
    for (int i = 1; i < DEPTH; i++) begin
      step(1, 0, 1, 8'h00);
      chk("full_wr_rd_order", 32'(bus.o_data_rd), 32'(8'h60 + i));
    end
    chk("full_wr_rd_dropped", 32'(bus.o_empty), 32'd1);

    // ---- corner: reset mid-operation with both requests active ----
    for (int i = 0; i < 3; i++) step(1, 1, 0, 8'(8'h20 + i));
    step(1, 0, 1, 8'h00);
    step(0, 1, 1, 8'h44);
    chk("midrst_empty", 32'(bus.o_empty),   32'd1);
    chk("midrst_dout",  32'(bus.o_data_rd), 32'h00);

    // ---- randomized traffic with phase-varying bias ----
    for (int i = 0; i < 4000; i++) begin
      int pw;
      int pr;
      logic r;
      pw = ((i / 300) % 2 == 0) ? 75 : 30;
      pr = 105 - pw;
      r  = ($urandom_range(0, 249) != 0);
      step(r, ($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr),
           DW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule : tb_fifo_asynchronous
